// File: rtl/uart_pkg.sv
// Shared constants for the UART APB register block:
// register offsets, STATUS bit positions and the bus FSM states.
package uart_pkg;
  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_DIV_LO = 8'h08;
  localparam logic [7:0] ADDR_DIV_HI = 8'h0C;
  localparam logic [7:0] ADDR_CTRL   = 8'h10;

  localparam int DIV_RST_DEF = 54;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/uart_apb_regs.sv
// APB3 slave for the UART: DATA maps to FIFO push/pop strobes,
// plus baud divisor, control bit and FIFO status registers.
module uart_apb_regs
  import uart_pkg::*;
#(
  parameter int APB_AW  = 8,
  parameter int APB_DW  = 8,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = DIV_RST_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_DW-1:0] PWDATA,
  output logic              PREADY,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PSLVERR,
  input  logic [APB_DW-1:0] rx_ff_data,
  input  logic              rx_ff_empty,
  input  logic              rx_ff_full,
  output logic              rx_ff_rd_en,
  input  logic              tx_ff_empty,
  input  logic              tx_ff_full,
  output logic              tx_ff_wr_en,
  output logic [APB_DW-1:0] tx_ff_data,
  output logic [DIV_W-1:0]  DIVxR,
  output logic              tx_start
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t state;
  logic [CW-1:0] cnt;

  logic is_data, is_stat, is_lo, is_hi, is_ctrl;
  logic hit, err, blocked, access, can_go, tmo;
  logic [APB_DW-1:0] rd_val;
  logic [2*APB_DW-1:0] div_ext, div_lo_nx, div_hi_nx;

  always_comb begin
    is_data = PADDR == APB_AW'(ADDR_DATA);
    is_stat = PADDR == APB_AW'(ADDR_STATUS);
    is_lo   = PADDR == APB_AW'(ADDR_DIV_LO);
    is_hi   = PADDR == APB_AW'(ADDR_DIV_HI);
    is_ctrl = PADDR == APB_AW'(ADDR_CTRL);
    hit     = is_data | is_stat | is_lo | is_hi | is_ctrl;
    err     = !hit || (PWRITE && is_stat);
    blocked = is_data && (PWRITE ? tx_ff_full : rx_ff_empty);
    access  = PSEL && PENABLE;
    can_go  = access && !blocked
              && (state == IDLE || state == WAIT);
    tmo     = access && blocked
              && state == WAIT && cnt == CNT_MAX;
  end

  // Divisor is viewed as a zero-extended pair of bus-wide bytes
  always_comb begin
    div_ext = '0;
    div_ext[DIV_W-1:0] = DIVxR;
    div_lo_nx = div_ext;
    div_lo_nx[APB_DW-1:0] = PWDATA;
    div_hi_nx = div_ext;
    div_hi_nx[2*APB_DW-1:APB_DW] = PWDATA;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_data: rd_val = rx_ff_data;
      is_stat: begin
        rd_val[ST_RX_EMPTY] = rx_ff_empty;
        rd_val[ST_RX_FULL]  = rx_ff_full;
        rd_val[ST_TX_EMPTY] = tx_ff_empty;
        rd_val[ST_TX_FULL]  = tx_ff_full;
      end
      is_lo:   rd_val = div_ext[APB_DW-1:0];
      is_hi:   rd_val = div_ext[2*APB_DW-1:APB_DW];
      is_ctrl: rd_val[0] = tx_start;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      PREADY      <= 1'b0;
      PRDATA      <= '0;
      PSLVERR     <= 1'b0;
      rx_ff_rd_en <= 1'b0;
      tx_ff_wr_en <= 1'b0;
      tx_ff_data  <= '0;
      DIVxR       <= DIV_W'(DIV_RST);
      tx_start    <= 1'b0;
    end else begin
      rx_ff_rd_en <= 1'b0;
      tx_ff_wr_en <= 1'b0;
      if (can_go) begin
        state   <= RESP;
        PREADY  <= 1'b1;
        PSLVERR <= err;
        PRDATA  <= (err || PWRITE) ? '0 : rd_val;
        if (!err && PWRITE) begin
          if (is_data) begin
            tx_ff_data  <= PWDATA;
            tx_ff_wr_en <= 1'b1;
          end
          if (is_lo)   DIVxR    <= div_lo_nx[DIV_W-1:0];
          if (is_hi)   DIVxR    <= div_hi_nx[DIV_W-1:0];
          if (is_ctrl) tx_start <= PWDATA[0];
        end
        if (!err && !PWRITE && is_data)
          rx_ff_rd_en <= 1'b1;
      end else if (tmo) begin
        state   <= RESP;
        PREADY  <= 1'b1;
        PSLVERR <= 1'b1;
        PRDATA  <= '0;
      end else begin
        unique case (state)
          IDLE: if (access) begin
            state <= WAIT;
            cnt   <= cnt + 1'b1;
          end
          WAIT: if (!access) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          RESP: begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            cnt     <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_regs.sv
// Directed bench for uart_apb_regs: register map, FIFO strobes,
// wait/timeout behaviour, abort and reset mid-transfer.
module tb_uart_apb_regs;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;
  logic       PSLVERR;
  logic [7:0] rx_ff_data;
  logic       rx_ff_empty, rx_ff_full, rx_ff_rd_en;
  logic       tx_ff_empty, tx_ff_full, tx_ff_wr_en;
  logic [7:0] tx_ff_data;
  logic [15:0] DIVxR;
  logic       tx_start;

  int n_checks = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_mis = 0;

  uart_apb_regs dut (
    .clk(clk), .rst(rst),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .rx_ff_data(rx_ff_data), .rx_ff_empty(rx_ff_empty),
    .rx_ff_full(rx_ff_full), .rx_ff_rd_en(rx_ff_rd_en),
    .tx_ff_empty(tx_ff_empty), .tx_ff_full(tx_ff_full),
    .tx_ff_wr_en(tx_ff_wr_en), .tx_ff_data(tx_ff_data),
    .DIVxR(DIVxR), .tx_start(tx_start)
  );

  always #5 clk = ~clk;

  // Strobe monitor; a strobe without PREADY is a misalignment
  always @(negedge clk) begin
    if (tx_ff_wr_en) n_wr++;
    if (rx_ff_rd_en) n_rd++;
    if ((tx_ff_wr_en || rx_ff_rd_en) && !PREADY) n_mis++;
  end

  task automatic clr_mon();
    n_wr = 0; n_rd = 0; n_mis = 0;
  endtask

  // lat = access cycle (1-based) in which PREADY is seen
  task automatic apb(input logic [7:0] a, input logic w,
                     input logic [7:0] d, input int maxc,
                     output logic [7:0] rd, output logic er,
                     output int lat);
    @(posedge clk); #1;
    PADDR = a; PWRITE = w; PWDATA = d;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    lat = 1;
    while (!PREADY && lat < maxc) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = PRDATA;
    er = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic er; int lat;
    n_checks++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
      n_err++; $display("FAIL reset_bus: got %b%b want 00", PREADY, PSLVERR);
    end
    n_checks++;
    if (DIVxR !== 16'd54) begin
      n_err++; $display("FAIL reset_div: got %h want 0036", DIVxR);
    end
    n_checks++;
    if (tx_start !== 1'b0 || tx_ff_data !== 8'h00) begin
      n_err++; $display("FAIL reset_out: got %b %h want 0 00", tx_start, tx_ff_data);
    end
    apb(8'h08, 1'b0, 8'h00, 10, rd, er, lat);
    n_checks++;
    if (rd !== 8'h36 || er !== 1'b0) begin
      n_err++; $display("FAIL rd_div_lo: got %h/%b want 36/0", rd, er);
    end
    apb(8'h0C, 1'b0, 8'h00, 10, rd, er, lat);
    n_checks++;
    if (rd !== 8'h00 || er !== 1'b0) begin
      n_err++; $display("FAIL rd_div_hi: got %h/%b want 00/0", rd, er);
    end
    apb(8'h10, 1'b0, 8'h00, 10, rd, er, lat);
    n_checks++;
    if (rd !== 8'h00 || er !== 1'b0) begin
      n_err++; $display("FAIL rd_ctrl: got %h/%b want 00/0", rd, er);
    end
  endtask

  task automatic test_tx_write();
    logic [7:0] rd; logic er; int lat;
    clr_mon();
    apb(8'h00, 1'b1, 8'hA5, 10, rd, er, lat);
    n_checks++;
    if (lat !== 2 || er !== 1'b0) begin
      n_err++; $display("FAIL tx_wr_lat: got %0d/%b want 2/0", lat, er);
    end
    n_checks++;
    if (n_wr !== 1 || n_mis !== 0 || n_rd !== 0) begin
      n_err++; $display("FAIL tx_wr_strobe: got wr=%0d mis=%0d rd=%0d want 1 0 0", n_wr, n_mis, n_rd);
    end
    n_checks++;
    if (tx_ff_data !== 8'hA5) begin
      n_err++; $display("FAIL tx_wr_data: got %h want a5", tx_ff_data);
    end
  endtask

  task automatic test_rx_read();
    logic [7:0] rd; logic er; int lat;
    clr_mon();
    rx_ff_data = 8'h3C; rx_ff_empty = 1'b0;
    apb(8'h00, 1'b0, 8'h00, 10, rd, er, lat);
    rx_ff_empty = 1'b1;
    n_checks++;
    if (rd !== 8'h3C || er !== 1'b0 || lat !== 2) begin
      n_err++; $display("FAIL rx_rd: got %h/%b/%0d want 3c/0/2", rd, er, lat);
    end
    n_checks++;
    if (n_rd !== 1 || n_mis !== 0 || n_wr !== 0) begin
      n_err++; $display("FAIL rx_rd_strobe: got rd=%0d mis=%0d wr=%0d want 1 0 0", n_rd, n_mis, n_wr);
    end
  endtask

  task automatic test_rx_wait();
    logic [7:0] rd; logic er; int lat;
    clr_mon();
    rx_ff_empty = 1'b1; rx_ff_data = 8'h00;
    fork
      apb(8'h00, 1'b0, 8'h00, 30, rd, er, lat);
      begin
        repeat (7) @(posedge clk);
        #1;
        rx_ff_data = 8'h11; rx_ff_empty = 1'b0;
      end
    join
    rx_ff_empty = 1'b1;
    n_checks++;
    if (rd !== 8'h11 || er !== 1'b0) begin
      n_err++; $display("FAIL rx_wait_data: got %h/%b want 11/0", rd, er);
    end
    // FIFO becomes non-empty in access cycle 6, PREADY one cycle later
    n_checks++;
    if (lat !== 7) begin
      n_err++; $display("FAIL rx_wait_lat: got %0d want 7", lat);
    end
    n_checks++;
    if (n_rd !== 1 || n_mis !== 0) begin
      n_err++; $display("FAIL rx_wait_strobe: got rd=%0d mis=%0d want 1 0", n_rd, n_mis);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] rd; logic er; int lat;
    clr_mon();
    tx_ff_full = 1'b1;
    apb(8'h00, 1'b1, 8'h77, 40, rd, er, lat);
    tx_ff_full = 1'b0;
    // 16 wait states -> PREADY in access cycle 17
    n_checks++;
    if (lat !== 17 || er !== 1'b1) begin
      n_err++; $display("FAIL timeout: got lat=%0d err=%b want 17/1", lat, er);
    end
    n_checks++;
    if (n_wr !== 0 || tx_ff_data !== 8'hA5) begin
      n_err++; $display("FAIL timeout_strobe: got wr=%0d data=%h want 0 a5", n_wr, tx_ff_data);
    end
  endtask

  task automatic test_div_unmapped();
    logic [7:0] rd; logic er; int lat;
    apb(8'h0C, 1'b1, 8'h01, 10, rd, er, lat);
    apb(8'h08, 1'b1, 8'h00, 10, rd, er, lat);
    n_checks++;
    if (DIVxR !== 16'h0100 || er !== 1'b0) begin
      n_err++; $display("FAIL div_wr: got %h/%b want 0100/0", DIVxR, er);
    end
    apb(8'h0C, 1'b0, 8'h00, 10, rd, er, lat);
    n_checks++;
    if (rd !== 8'h01) begin
      n_err++; $display("FAIL div_hi_rb: got %h want 01", rd);
    end
    clr_mon();
    apb(8'h14, 1'b1, 8'hFF, 10, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || lat !== 2 || n_wr !== 0) begin
      n_err++; $display("FAIL unmapped_wr: got err=%b lat=%0d wr=%0d want 1 2 0", er, lat, n_wr);
    end
    apb(8'h04, 1'b1, 8'hFF, 10, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || lat !== 2) begin
      n_err++; $display("FAIL status_wr: got err=%b lat=%0d want 1 2", er, lat);
    end
  endtask

  task automatic test_status();
    logic [7:0] rd; logic er; int lat;
    tx_ff_full = 1'b0; tx_ff_empty = 1'b1;
    rx_ff_full = 1'b1; rx_ff_empty = 1'b0;
    apb(8'h04, 1'b0, 8'h00, 10, rd, er, lat);
    rx_ff_full = 1'b0; rx_ff_empty = 1'b1;
    n_checks++;
    if (rd !== 8'h06 || er !== 1'b0) begin
      n_err++; $display("FAIL status_rd: got %h/%b want 06/0", rd, er);
    end
  endtask

  task automatic test_abort();
    int seen;
    clr_mon();
    seen = 0;
    rx_ff_empty = 1'b1;
    @(posedge clk); #1;
    PADDR = 8'h00; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (PREADY) seen++;
    end
    n_checks++;
    if (seen !== 0 || n_rd !== 0) begin
      n_err++; $display("FAIL abort: got ready=%0d rd=%0d want 0 0", seen, n_rd);
    end
  endtask

  task automatic test_rst_mid_wait();
    logic [7:0] rd; logic er; int lat;
    apb(8'h10, 1'b1, 8'h01, 10, rd, er, lat);
    n_checks++;
    if (tx_start !== 1'b1) begin
      n_err++; $display("FAIL ctrl_wr: got %b want 1", tx_start);
    end
    clr_mon();
    tx_ff_full = 1'b1;
    @(posedge clk); #1;
    PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 8'h5A;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (DIVxR !== 16'd54 || tx_start !== 1'b0) begin
      n_err++; $display("FAIL rst_regs: got %h/%b want 0036/0", DIVxR, tx_start);
    end
    n_checks++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || tx_ff_data !== 8'h00) begin
      n_err++; $display("FAIL rst_bus: got %b%b %h want 00 00", PREADY, PSLVERR, tx_ff_data);
    end
    PSEL = 1'b0; PENABLE = 1'b0; tx_ff_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (n_wr !== 0 || n_rd !== 0) begin
      n_err++; $display("FAIL rst_strobe: got wr=%0d rd=%0d want 0 0", n_wr, n_rd);
    end
    apb(8'h08, 1'b0, 8'h00, 10, rd, er, lat);
    n_checks++;
    if (rd !== 8'h36 || er !== 1'b0 || lat !== 2) begin
      n_err++; $display("FAIL post_rst_rd: got %h/%b/%0d want 36/0/2", rd, er, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PWDATA = '0;
    rx_ff_data = '0; rx_ff_empty = 1'b1; rx_ff_full = 1'b0;
    tx_ff_empty = 1'b1; tx_ff_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_tx_write();
    test_rx_read();
    test_rx_wait();
    test_timeout();
    test_div_unmapped();
    test_status();
    test_abort();
    test_rst_mid_wait();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
